// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment display controller:
// source indices, default timing parameters and the hex-to-segment table.
package seg7_pkg;

    localparam int unsigned DEF_SCAN_DIV   = 50000;
    localparam int unsigned DEF_DEB_CYCLES = 1000000;

    localparam logic [2:0] SRC_DISP = 3'd0;
    localparam logic [2:0] SRC_J    = 3'd1;
    localparam logic [2:0] SRC_R    = 3'd2;
    localparam logic [2:0] SRC_I    = 3'd3;
    localparam logic [2:0] SRC_TC   = 3'd4;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[n] decodes nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] segDecode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_debouncer.sv
// Button conditioning: 2-flop synchronizer, stable-count debounce and a
// registered one-cycle pulse on each accepted rising level.
module seg7_debouncer
    import seg7_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] count;
    logic             accept;

    assign accept = (sync2 != level) && (count == CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            press <= accept && sync2;
            if (sync2 == level) begin
                count <= '0;
            end else if (accept) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Scans one of five 32-bit sources across eight multiplexed hex digits,
// with a debounced button cycling the selected source.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp,
    input  logic [31:0] statJ,
    input  logic [31:0] statR,
    input  logic [31:0] statI,
    input  logic [31:0] statTC,
    input  logic        btn_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [2:0]  src
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             press;
    logic [PRE_W-1:0] prescaler;
    logic [2:0]       index;
    logic [31:0]      snapshot;
    logic [2:0]       snapSrc;
    logic [31:0]      selData;
    logic [31:0]      shownData;
    logic [2:0]       shownSrc;
    logic [3:0]       curNib;
    logic             frameStart;
    logic             dpN;

    seg7_debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .btnRaw(btn_sel),
        .press (press)
    );

    always_comb begin
        selData = disp;
        case (src)
            SRC_J:   selData = statJ;
            SRC_R:   selData = statR;
            SRC_I:   selData = statI;
            SRC_TC:  selData = statTC;
            default: selData = disp;
        endcase
    end

    assign frameStart = (prescaler == '0) && (index == '0);

    // Bypass the snapshot on frame start so digit 0 shows the fresh value at once.
    assign shownData = frameStart ? selData : snapshot;
    assign shownSrc  = frameStart ? src : snapSrc;
    assign curNib    = shownData[{index, 2'b00} +: 4];
    assign dpN       = !((index == 3'd0) && (shownSrc != SRC_DISP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            index     <= '0;
            snapshot  <= '0;
            snapSrc   <= SRC_DISP;
            src       <= SRC_DISP;
            an        <= 8'hFF;
            seg       <= 8'hFF;
        end else begin
            if (press) begin
                src <= (src == SRC_TC) ? SRC_DISP : src + 3'd1;
            end
            if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
                prescaler <= '0;
                index     <= index + 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (frameStart) begin
                snapshot <= selData;
                snapSrc  <= src;
            end
            an  <= ~(8'd1 << index);
            seg <= {dpN, segDecode(curNib)};
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed + randomized bench for seg7_display_ctrl against a cycle-level
// behavioural model of scanning, snapshotting and button debounce.
module tb_seg7_display_ctrl;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] disp = '0;
    logic [31:0] statJ = '0;
    logic [31:0] statR = '0;
    logic [31:0] statI = '0;
    logic [31:0] statTC = '0;
    logic        btn_sel = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [2:0]  src;

    seg7_display_ctrl #(
        .SCAN_DIV  (SD),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .disp   (disp),
        .statJ  (statJ),
        .statR  (statR),
        .statI  (statI),
        .statTC (statTC),
        .btn_sel(btn_sel),
        .an     (an),
        .seg    (seg),
        .src    (src)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] segByte [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state
    int unsigned n;
    logic [31:0] mSnap;
    logic [2:0]  mSnapSrc;
    logic [2:0]  mSrc;
    logic        mLevel;
    logic        mPend;
    logic        rawHist[$];
    logic        win[$];
    logic [7:0]  expAn;
    logic [7:0]  expSeg;

    function automatic logic [31:0] pick(input logic [2:0] s);
        case (s)
            3'd1:    return statJ;
            3'd2:    return statR;
            3'd3:    return statI;
            3'd4:    return statTC;
            default: return disp;
        endcase
    endfunction

    task automatic modelReset();
        n = 0;
        mSnap = '0;
        mSnapSrc = '0;
        mSrc = '0;
        mLevel = 1'b0;
        mPend = 1'b0;
        rawHist.delete();
        win.delete();
    endtask

    task automatic modelEdge();
        int unsigned t;
        int unsigned idx;
        logic [3:0]  nib;
        logic        syncVal;
        logic        allDiff;
        t = n;
        n++;
        idx = (t / SD) % 8;
        if (t % (SD * 8) == 0) begin
            mSnap = pick(mSrc);
            mSnapSrc = mSrc;
        end
        nib = mSnap[idx*4 +: 4];
        expAn = ~(8'd1 << idx);
        expSeg = segByte[nib] & (((idx == 0) && (mSnapSrc != 0)) ? 8'h7F : 8'hFF);
        if (mPend) mSrc = (mSrc == 3'd4) ? 3'd0 : mSrc + 3'd1;
        mPend = 1'b0;
        // Button level seen at this edge is the raw sample from two edges back.
        syncVal = (rawHist.size() >= 2) ? rawHist[rawHist.size()-2] : 1'b0;
        win.push_back(syncVal);
        if (win.size() > DEB) void'(win.pop_front());
        if (win.size() == DEB) begin
            allDiff = 1'b1;
            foreach (win[i]) if (win[i] == mLevel) allDiff = 1'b0;
            if (allDiff) begin
                mLevel = ~mLevel;
                mPend = mLevel;
            end
        end
        rawHist.push_back(btn_sel);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        check("an", an, expAn);
        check("seg", seg, expSeg);
        check("src", src, mSrc);
    endtask

    task automatic tickReset();
        @(posedge clk);
        #1;
        check("rstAn", an, 8'hFF);
        check("rstSeg", seg, 8'hFF);
        check("rstSrc", src, 3'd0);
    endtask

    task automatic pulse(input int len);
        btn_sel = 1'b1;
        repeat (len) tick();
        btn_sel = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int runLeft;
        modelReset();
        #1 reset = 1'b0;
        #1;
        check("asyncAn", an, 8'hFF);
        check("asyncSeg", seg, 8'hFF);
        check("asyncSrc", src, 3'd0);
        repeat (2) tickReset();

        // Basic scan of a known value, then a mid-frame change
        disp = 32'h12345678;
        statJ = 32'h9ABCDEF0;
        statR = $urandom;
        statI = $urandom;
        statTC = $urandom;
        reset = 1'b1;
        for (int i = 0; i < 96; i++) begin
            tick();
            if (i == 0) begin
                check("dig0An", an, 8'hFE);
                check("dig0Seg", seg, 8'h80);
            end
            if (i == 28) begin
                check("dig7An", an, 8'h7F);
                check("dig7Seg", seg, 8'hF9);
            end
            if (i >= 64) check("allF", seg, 8'h8E);
            if (i == 45) disp = 32'hFFFFFFFF;
        end

        // Short glitches must not count; a solid press advances once
        pulse(1);
        pulse(2);
        check("glitchSrc", src, 3'd0);
        pulse(6);
        check("press1Src", src, 3'd1);
        repeat (40) tick();

        // Asynchronous reset mid-frame with the debounce mid-count
        btn_sel = 1'b1;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        check("midRstAn", an, 8'hFF);
        check("midRstSeg", seg, 8'hFF);
        check("midRstSrc", src, 3'd0);
        modelReset();
        repeat (3) tickReset();
        btn_sel = 1'b0;
        disp = $urandom;
        reset = 1'b1;
        repeat (40) tick();

        // Five clean presses walk the full source ring
        for (int p = 0; p < 5; p++) begin
            statJ = $urandom;
            statR = $urandom;
            statI = $urandom;
            statTC = $urandom;
            btn_sel = 1'b1;
            repeat (6) tick();
            btn_sel = 1'b0;
            repeat (6) tick();
            check("srcSeq", src, 32'((p + 1) % 5));
            repeat (34) tick();
        end
        repeat (40) tick();

        // Random button activity and data
        runLeft = 0;
        for (int i = 0; i < 400; i++) begin
            if (runLeft == 0) begin
                btn_sel = ~btn_sel;
                runLeft = $urandom_range(1, 7);
            end
            runLeft--;
            if ($urandom_range(0, 3) == 0) begin
                disp = $urandom;
                statJ = $urandom;
                statR = $urandom;
                statI = $urandom;
                statTC = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
